mandel_pixel_scheduler: RTL and testbench

//  Frame-level sequencer for a bank of NUM_ENG depth_calculator engines. Walks the

---
 rtl/mandel_pixel_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_mandel_pixel_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_pixel_scheduler.sv
// Frame sequencer for a bank of depth engines.
// Walks the raster, dispatches round-robin and retires results in raster order.
module mandel_pixel_scheduler #(
   parameter int NUM_ENG = 4,
   parameter int FRAC    = 16,
   parameter int FRAME_W = 640,
   parameter int FRAME_H = 480
) (
   input  logic                 sysclk,
   input  logic                 reset_n,
   input  logic                 frame_start,
   input  logic [31:0]          cfg_re_start,
   input  logic [31:0]          cfg_im_start,
   input  logic [31:0]          cfg_step,
   output logic                 busy,
   output logic                 frame_done,
   output logic [NUM_ENG-1:0]   eng_start,
   output logic [9:0]           eng_x,
   output logic [8:0]           eng_y,
   output logic [31:0]          eng_re_c,
   output logic [31:0]          eng_im_c,
   input  logic [NUM_ENG-1:0]   eng_done,
   input  logic [8*NUM_ENG-1:0] eng_depth,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic [9:0]           pix_x,
   output logic [8:0]           pix_y,
   output logic [7:0]           pix_depth,
   output logic                 pix_last
);

   localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam logic [9:0]    X_LAST = 10'(FRAME_W - 1);
   localparam logic [8:0]    Y_LAST = 9'(FRAME_H - 1);
   localparam logic [PW-1:0] P_LAST = PW'(NUM_ENG - 1);

   // Marker scope that only elaborates for an unsupported configuration
   if (NUM_ENG < 1 || NUM_ENG > 8 || FRAC < 0 || FRAC > 31 ||
       FRAME_W < 1 || FRAME_W > 1024 ||
       FRAME_H < 1 || FRAME_H > 512) begin : g_bad_params
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [9:0]          x_q;
   logic [8:0]          y_q;
   logic [31:0]         re_q, im_q, re0_q, step_q;
   logic [PW-1:0]       dp_q, rp_q;
   logic [NUM_ENG-1:0]  eng_busy_q, eng_busy_d;
   logic [NUM_ENG-1:0]  done_eff;
   logic [9:0]          tag_x [NUM_ENG];
   logic [8:0]          tag_y [NUM_ENG];
   logic [7:0]          depth_arr [NUM_ENG];
   logic                dispatch, retire, last_hs;

   assign eng_x    = x_q;
   assign eng_y    = y_q;
   assign eng_re_c = re_q;
   assign eng_im_c = im_q;

   assign last_hs  = pix_valid && pix_ready && pix_last;
   // Done seen in a start cycle belongs to the previous result
   assign done_eff = eng_done & ~eng_start;
   assign retire   = eng_busy_q[rp_q] && done_eff[rp_q] &&
                     (!pix_valid || pix_ready);

   // State register
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state, busy flag and dispatch decision
   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      dispatch = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (frame_start) state_d = S_RUN;
         end
         S_RUN: begin
            busy     = 1'b1;
            dispatch = !eng_busy_q[dp_q];
            if (dispatch && x_q == X_LAST && y_q == Y_LAST)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (last_hs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // One-hot start pulse to the engine under the dispatch pointer
   always_comb begin
      eng_start = '0;
      if (dispatch) eng_start[dp_q] = 1'b1;
   end

   // Unpack per-engine depth results
   always_comb begin
      for (int k = 0; k < NUM_ENG; k++)
         depth_arr[k] = eng_depth[8*k +: 8];
   end

   // Engine occupancy: set on dispatch, cleared on retire
   always_comb begin
      eng_busy_d = eng_busy_q;
      if (dispatch) eng_busy_d[dp_q] = 1'b1;
      if (retire)   eng_busy_d[rp_q] = 1'b0;
   end

   // Raster position and incremental complex coordinate
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         x_q    <= '0;
         y_q    <= '0;
         re_q   <= '0;
         im_q   <= '0;
         re0_q  <= '0;
         step_q <= '0;
      end else if (state_q == S_IDLE && frame_start) begin
         x_q    <= '0;
         y_q    <= '0;
         re_q   <= cfg_re_start;
         im_q   <= cfg_im_start;
         re0_q  <= cfg_re_start;
         step_q <= cfg_step;
      end else if (dispatch) begin
         if (x_q == X_LAST) begin
            x_q  <= '0;
            y_q  <= y_q + 9'd1;
            re_q <= re0_q;
            im_q <= im_q - step_q;
         end else begin
            x_q  <= x_q + 10'd1;
            re_q <= re_q + step_q;
         end
      end
   end

   // Pointers, occupancy and per-engine coordinate tags
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         dp_q       <= '0;
         rp_q       <= '0;
         eng_busy_q <= '0;
         for (int k = 0; k < NUM_ENG; k++) begin
            tag_x[k] <= '0;
            tag_y[k] <= '0;
         end
      end else begin
         eng_busy_q <= eng_busy_d;
         if (dispatch) begin
            tag_x[dp_q] <= x_q;
            tag_y[dp_q] <= y_q;
            dp_q        <= (dp_q == P_LAST) ? '0 : dp_q + PW'(1);
         end
         if (retire)
            rp_q <= (rp_q == P_LAST) ? '0 : rp_q + PW'(1);
      end
   end

   // Single output register; holds until accepted downstream
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_depth <= '0;
         pix_last  <= 1'b0;
      end else if (retire) begin
         pix_valid <= 1'b1;
         pix_x     <= tag_x[rp_q];
         pix_y     <= tag_y[rp_q];
         pix_depth <= depth_arr[rp_q];
         pix_last  <= (tag_x[rp_q] == X_LAST) && (tag_y[rp_q] == Y_LAST);
      end else if (pix_ready) begin
         pix_valid <= 1'b0;
      end
   end

   // Frame completion pulse after the last pixel handshake
   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) frame_done <= 1'b0;
      else          frame_done <= (state_q == S_DRAIN) && last_hs;
   end

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler on a 4x2 frame with 2 engines.
// Engine model with programmable latency; monitor checks dispatch and output.
`timescale 1ns/1ps
module tb_mandel_pixel_scheduler;
   localparam int N = 2;
   localparam int W = 4;
   localparam int H = 2;

   logic           sysclk = 1'b0;
   logic           reset_n = 1'b0;
   logic           frame_start = 1'b0;
   logic [31:0]    cfg_re_start = '0;
   logic [31:0]    cfg_im_start = '0;
   logic [31:0]    cfg_step = '0;
   logic           busy, frame_done;
   logic [N-1:0]   eng_start;
   logic [9:0]     eng_x;
   logic [8:0]     eng_y;
   logic [31:0]    eng_re_c, eng_im_c;
   logic [N-1:0]   eng_done;
   logic [8*N-1:0] eng_depth;
   logic           pix_valid;
   logic           pix_ready = 1'b0;
   logic [9:0]     pix_x;
   logic [8:0]     pix_y;
   logic [7:0]     pix_depth;
   logic           pix_last;

   mandel_pixel_scheduler #(
      .NUM_ENG(N), .FRAC(16), .FRAME_W(W), .FRAME_H(H)
   ) dut (
      .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
      .cfg_re_start(cfg_re_start), .cfg_im_start(cfg_im_start),
      .cfg_step(cfg_step), .busy(busy), .frame_done(frame_done),
      .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
      .eng_re_c(eng_re_c), .eng_im_c(eng_im_c), .eng_done(eng_done),
      .eng_depth(eng_depth), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth),
      .pix_last(pix_last)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [31:0] re;
      logic [31:0] im;
   } disp_t;

   typedef struct {
      int         idx;
      logic [9:0] x;
      logic [8:0] y;
      logic [7:0] d;
      logic       last;
   } pix_t;

   disp_t exp_disp[$];
   pix_t  exp_pix[$];
   disp_t dm;
   pix_t  pm;

   logic [31:0] re_tab [2][4] = '{
      '{32'hFFFE0000, 32'hFFFE8000, 32'hFFFF0000, 32'hFFFF8000},
      '{32'h7FFF8000, 32'h80008000, 32'h80018000, 32'h80028000}};
   logic [31:0] im_tab [2][2] = '{
      '{32'h00010000, 32'h00008000},
      '{32'h80000000, 32'h7FFF0000}};
   logic [7:0] dep_tab [8] = '{8'h20, 8'h21, 8'h22, 8'h23,
                               8'h30, 8'h31, 8'h32, 8'h33};

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Engine model: done rises lat cycles after start, held until next start
   int lat_mode = 0;
   int cnt [N];

   function automatic int lat_of(input int idx);
      case (lat_mode)
         1:       return (idx == 0) ? 20 : 3;
         2:       return (idx == 0) ? 5 : ((idx == 1) ? 4 : 3);
         3:       return 30;
         default: return 3;
      endcase
   endfunction

   always @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         eng_done  <= '0;
         eng_depth <= '0;
         for (int k = 0; k < N; k++) cnt[k] <= 0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (eng_start[k]) begin
               eng_done[k]         <= 1'b0;
               cnt[k]              <= lat_of(int'(eng_y) * W + int'(eng_x));
               eng_depth[8*k +: 8] <= 8'(32 + 16 * int'(eng_y) + int'(eng_x));
            end else if (cnt[k] != 0) begin
               cnt[k] <= cnt[k] - 1;
               if (cnt[k] == 1) eng_done[k] <= 1'b1;
            end
         end
      end
   end

   // Monitor: pops expectations on dispatch and on output handshake
   int disp_total = 0, hs_total = 0, done_total = 0;
   int outst = 0, max_out = 0, cyc = 0;
   int hs_cyc0 = 0, hs_cyc1 = 0, last_hs_cyc = 0;
   logic        hold = 1'b0;
   logic [27:0] held = '0;

   always @(negedge sysclk) begin
      cyc++;
      if (!reset_n) begin
         exp_disp.delete();
         exp_pix.delete();
         outst = 0;
         hold  = 1'b0;
      end else begin
         if (eng_start != '0) begin
            disp_total++;
            outst++;
            if (outst > max_out) max_out = outst;
            chk("start_onehot", $onehot(eng_start), 1);
            chk("disp_pending", exp_disp.size() > 0, 1);
            if (exp_disp.size() > 0) begin
               dm = exp_disp.pop_front();
               chk("eng_x", eng_x, dm.x);
               chk("eng_y", eng_y, dm.y);
               chk("eng_re_c", eng_re_c, dm.re);
               chk("eng_im_c", eng_im_c, dm.im);
            end
         end
         if (hold)
            chk("pix_stable", {pix_valid, pix_x, pix_y, pix_depth, pix_last},
                {1'b1, held});
         hold = pix_valid && !pix_ready;
         held = {pix_x, pix_y, pix_depth, pix_last};
         if (pix_valid && pix_ready) begin
            hs_total++;
            outst--;
            last_hs_cyc = cyc;
            chk("pix_pending", exp_pix.size() > 0, 1);
            if (exp_pix.size() > 0) begin
               pm = exp_pix.pop_front();
               chk("pix_x", pix_x, pm.x);
               chk("pix_y", pix_y, pm.y);
               chk("pix_depth", pix_depth, pm.d);
               chk("pix_last", pix_last, pm.last);
               if (pm.idx == 0) hs_cyc0 = cyc;
               if (pm.idx == 1) hs_cyc1 = cyc;
            end
         end
         if (frame_done) begin
            done_total++;
            chk("done_sb_empty", exp_pix.size(), 0);
            chk("done_after_last_hs", cyc > last_hs_cyc, 1);
         end
      end
   end

   int fr_p0 = 0, fr_h0 = 0, fr_d0 = 0;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic push_frame(input int cs);
      disp_t d;
      pix_t  p;
      for (int i = 0; i < W * H; i++) begin
         d.x  = 10'(i % W);
         d.y  = 9'(i / W);
         d.re = re_tab[cs][i % W];
         d.im = im_tab[cs][i / W];
         exp_disp.push_back(d);
         p.idx  = i;
         p.x    = 10'(i % W);
         p.y    = 9'(i / W);
         p.d    = dep_tab[i];
         p.last = (i == W * H - 1);
         exp_pix.push_back(p);
      end
   endtask

   task automatic start_frame(input int cs, input int mode,
                              input logic [31:0] re, input logic [31:0] im,
                              input logic [31:0] st);
      lat_mode     = mode;
      cfg_re_start = re;
      cfg_im_start = im;
      cfg_step     = st;
      fr_p0 = disp_total;
      fr_h0 = hs_total;
      fr_d0 = done_total;
      push_frame(cs);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_frame();
      int t = 0;
      while (done_total == fr_d0 && t < 3000) begin
         tick();
         t++;
      end
      chk("frame_done_seen", done_total != fr_d0, 1);
      tick(5);
      chk("frame_done_once", done_total - fr_d0, 1);
      chk("pix_count", hs_total - fr_h0, W * H);
      chk("disp_count", disp_total - fr_p0, W * H);
      chk("busy_after_frame", busy, 0);
      chk("sb_empty", exp_pix.size() + exp_disp.size(), 0);
   endtask

   initial begin
      int t;
      int d0;
      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_pix_bus", {pix_x, pix_y, pix_depth, pix_last}, 0);
      chk("rst_eng_bus", {eng_x, eng_y, eng_re_c, eng_im_c}, 0);
      reset_n = 1'b1;
      tick(2);

      // Coordinate sequence; two engines finishing together
      pix_ready = 1'b1;
      start_frame(0, 2, 32'hFFFE0000, 32'h00010000, 32'h00008000);
      wait_frame();
      chk("back_to_back", hs_cyc1 - hs_cyc0, 1);

      // Slow first pixel: later results wait for it
      start_frame(0, 1, 32'hFFFE0000, 32'h00010000, 32'h00008000);
      wait_frame();

      // Ignored frame_start during RUN and a 50-cycle output stall
      start_frame(0, 0, 32'hFFFE0000, 32'h00010000, 32'h00008000);
      tick(2);
      cfg_re_start = 32'h12345678;
      cfg_im_start = 32'h9ABCDEF0;
      cfg_step     = 32'h00FF0000;
      frame_start  = 1'b1;
      tick();
      frame_start  = 1'b0;
      t = 0;
      while (hs_total - fr_h0 < 2 && t < 200) begin
         tick();
         t++;
      end
      chk("stall_point", hs_total - fr_h0 >= 2, 1);
      pix_ready = 1'b0;
      tick(50);
      pix_ready = 1'b1;
      wait_frame();
      chk("max_outstanding", max_out <= N + 1, 1);

      // Reset in DRAIN abandons the frame
      start_frame(0, 3, 32'hFFFE0000, 32'h00010000, 32'h00008000);
      t = 0;
      while (disp_total - fr_p0 < W * H && t < 2000) begin
         tick();
         t++;
      end
      chk("drain_reached", disp_total - fr_p0, W * H);
      tick(2);
      d0 = done_total;
      reset_n = 1'b0;
      @(negedge sysclk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_pix_valid", pix_valid, 0);
      chk("mid_rst_eng_start", eng_start, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      chk("mid_rst_outputs",
          {pix_x, pix_y, pix_depth, pix_last, eng_x, eng_y, eng_re_c, eng_im_c},
          0);
      tick(2);
      reset_n = 1'b1;
      tick(20);
      chk("no_done_after_reset", done_total - d0, 0);

      // Fresh frame after reset, wrapping coordinate arithmetic
      start_frame(1, 0, 32'h7FFF8000, 32'h80000000, 32'h00010000);
      wait_frame();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
